// File: rtl/mux_arb_pkg.sv
// Shared constants for the two-requester mux arbiter: state encoding and
// default hold-limit sizing.
package mux_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam int DEF_HOLD_MAX = 8;
  localparam int DEF_CNT_W    = 4;

  function automatic logic is_own(input logic [1:0] st);
    return (st == ST_OWN0) || (st == ST_OWN1);
  endfunction

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Hold counter for the current grant owner: clears on entry, counts up while
// the owner keeps the grant, saturates and flags terminal count at HOLD_MAX-1.
module mux_arb_hold_cnt
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select line of a shared two-input mux;
// one-hot registered grants with a hold limit against monopolisation.
//
//   state | meaning
//   IDLE  | no grant; sel keeps its last value
//   OWN0  | requester 0 granted, sel=0
//   OWN1  | requester 1 granted, sel=1
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             last_q;
  logic             last_d;
  logic             sel_q;
  logic             sel_d;
  logic             entering;
  logic             cnt_inc;
  logic             hold_tc;
  logic [CNT_W-1:0] hold_cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
        end else if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
      end
      // Release wins over preemption when both apply in the same cycle.
      ST_OWN0: begin
        if (!req0) begin
          state_d = req1 ? ST_OWN1 : ST_IDLE;
        end else if (hold_tc && req1) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          state_d = req0 ? ST_OWN0 : ST_IDLE;
        end else if (hold_tc && req0) begin
          state_d = ST_OWN0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    entering = is_own(state_d) && (state_d != state_q);
    cnt_inc  = is_own(state_q) && (state_d == state_q);
    last_d   = last_q;
    sel_d    = sel_q;
    if (entering) begin
      last_d = (state_d == ST_OWN1);
      sel_d  = (state_d == ST_OWN1);
    end
  end

  mux_arb_hold_cnt #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (entering),
    .inc (cnt_inc),
    .cnt (hold_cnt),
    .tc  (hold_tc)
  );

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt0 = (state_q == ST_OWN0);
  assign gnt1 = (state_q == ST_OWN1);
  assign busy = (state_q != ST_IDLE);
  assign sel  = sel_q;

  logic unused_cnt;
  assign unused_cnt = ^hold_cnt;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: scoreboard of expected {gnt0,gnt1,sel,busy} per edge
// from an owner/run-length reference model, directed scenarios plus random.
module tb_mux_arbiter;

  localparam int HM = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic busy;

  always #5 clk = ~clk;

  mux_arbiter #(.HOLD_MAX(HM), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .sel  (sel),
    .busy (busy)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  // Reference model: who owns the path, how many cycles it has held it,
  // who won last, and the current select value.
  int   m_owner;
  int   m_run;
  int   m_last;
  logic m_sel;

  function automatic void model_reset();
    m_owner = -1;
    m_run   = 0;
    m_last  = 1;
    m_sel   = 1'b0;
  endfunction

  function automatic logic [3:0] model_step(input bit r0, input bit r1, input bit in_rst);
    bit rq[2];
    int other;
    rq[0] = r0;
    rq[1] = r1;
    if (in_rst) begin
      model_reset();
      return 4'b0000;
    end
    if (m_owner < 0) begin
      if (r0 && r1)  m_owner = (m_last == 1) ? 0 : 1;
      else if (r0)   m_owner = 0;
      else if (r1)   m_owner = 1;
      m_run = 1;
    end else begin
      other = 1 - m_owner;
      if (!rq[m_owner]) begin
        m_owner = rq[other] ? other : -1;
        m_run   = 1;
      end else if (rq[other] && m_run >= HM) begin
        m_owner = other;
        m_run   = 1;
      end else begin
        m_run++;
      end
    end
    if (m_owner >= 0) begin
      m_last = m_owner;
      m_sel  = (m_owner == 1);
    end
    return {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0};
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got gnt0,gnt1,sel,busy=%b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r0, input bit r1, input bit r);
    @(posedge clk);
    #2;
    rst  = r;
    req0 = r0;
    req1 = r1;
    exp_q.push_back(model_step(r0, r1, r));
  endtask

  // Monitor: compares the outcome of each edge against the queued expectation.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {gnt0, gnt1, sel, busy}, e);
        check("onehot", {2'b00, gnt0 & gnt1, 1'b0}, 4'b0000);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit r0;
    bit r1;
    rst  = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    model_reset();
    #1;
    check("reset_t0", {gnt0, gnt1, sel, busy}, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", {gnt0, gnt1, sel, busy}, 4'b0000);

    // Release reset with both requesting: requester 0 wins the tie.
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    repeat (2) cyc(0, 0, 0);

    // req1 pulse: three grant cycles, sel sticks at 1 afterwards.
    repeat (3) cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);

    // Both held: alternating HM-cycle grants with no idle gap.
    repeat (40) cyc(1, 1, 0);
    repeat (2) cyc(0, 0, 0);

    // Long solo hold saturates, then the other side takes over after one edge.
    repeat (20) cyc(1, 0, 0);
    repeat (3) cyc(1, 1, 0);
    repeat (2) cyc(0, 0, 0);

    // Direct handover on simultaneous drop/raise.
    repeat (3) cyc(1, 0, 0);
    repeat (2) cyc(0, 1, 0);

    // Asynchronous reset mid-OWN1.
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("async_rst", {gnt0, gnt1, sel, busy}, 4'b0000);
    repeat (2) cyc(1, 1, 1);
    cyc(1, 1, 0);
    cyc(1, 1, 0);

    // Randomised requests with some persistence so holds and preemption occur.
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      cyc(r0, r1, 0);
    end
    repeat (2) cyc(0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares a single two-input multiplexer between two requesters. It owns the multiplexer select line and issues one-hot grants. A programmable hold limit stops either requester from monopolising the path. It sits directly in front of the shared multiplexer, and its `sel` output drives that multiplexer's select input.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum consecutive grant cycles while the other side is waiting; legal range 2..2**CNT_W.
- `CNT_W`, default 4: width of the hold counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  request from requester 0 (drives mux input I0).
- `req1`  in  1  request from requester 1 (drives mux input I1).
- `gnt0`  out  1  grant to requester 0; registered.
- `gnt1`  out  1  grant to requester 1; registered.
- `sel`  out  1  mux select: 0 routes I0, 1 routes I1; registered.
- `busy`  out  1  high whenever either grant is high.

## Operation
- States: IDLE, OWN0, OWN1. `gnt0` = (state==OWN0), `gnt1` = (state==OWN1), `busy` = (state!=IDLE). All outputs are decoded from registers only.
- `last` register records the most recently granted side; reset value 1, so requester 0 wins the first tie.
- IDLE transitions:
  - Only req0 high → OWN0.
  - Only req1 high → OWN1.
  - Both high → side opposite `last`.
  - Neither high → stay in IDLE.
- OWNx transitions, evaluated in this priority order:
  - reqx low and other side requesting → OWN(other) directly, no IDLE bubble.
  - reqx low and other side idle → IDLE.
  - `hold_cnt`==HOLD_MAX-1 and other side requesting → OWN(other) (preemption).
  - Otherwise → stay in OWNx.
- `hold_cnt`:
  - Cleared to 0 on every entry into OWN0/OWN1.
  - Increments each cycle in the same OWN state.
  - Saturates at HOLD_MAX-1 when the other side is not requesting; the owner keeps the grant indefinitely.
- `sel` is 0 in OWN0 and 1 in OWN1. In IDLE it retains its previous value, so the mux output does not glitch.
- `last` updates on every entry into OWN0/OWN1.
- Invariant: `gnt0` and `gnt1` are never high together.

## Timing
- Reset values: state=IDLE, `gnt0`=0, `gnt1`=0, `sel`=0, `busy`=0, `hold_cnt`=0, `last`=1.
- Grant latency: request sampled at edge k, grant high after edge k (one cycle from request to grant). `sel` changes on the same edge as the grant.
- Release latency: reqx low at edge k, `gntx` low after edge k.
- Preemption: with the other side waiting, the owner holds its grant exactly HOLD_MAX cycles.
- Handover: a switch OWN0↔OWN1 takes one edge. `gnt0` falls and `gnt1` rises on the same edge, with no overlap.
- Simultaneous events:
  - Release and preemption condition in the same cycle: treated as a release (same next state).
  - Both requests rising in the same IDLE cycle: resolved by `last`.
- Reset asserted mid-grant: all outputs drop to reset values immediately and asynchronously, with no clock needed. First grant after reset goes to requester 0 on a tie.

## Structure
- Shared package `mux_arb_pkg`:
  - State encoding: IDLE=2'b00, OWN0=2'b01, OWN1=2'b10.
  - Default HOLD_MAX/CNT_W constants.
- One sub-module, `mux_arb_hold_cnt`: clear, increment, saturate and terminal-count flag at HOLD_MAX-1.
- Top level holds the FSM, `last` and the output registers.

## Test plan
- Reset with req0=req1=1 → all outputs 0 during reset. First edge after release → `gnt0`=1, `sel`=0, `busy`=1.
- req1 alone pulsed for 3 cycles → `gnt1` high 3 cycles, starting one cycle after `req1` rises; `sel`=1 and stays 1 after return to IDLE.
- req0 and req1 held high, HOLD_MAX=8 → grants alternate: `gnt0` for 8 cycles, then `gnt1` for 8 cycles. Never both high, no IDLE cycle between.
- req0 held high for 20 cycles, req1 low → `gnt0` stays high all 20 cycles and the counter saturates. Raise req1 → `gnt1` after exactly one more cycle.
- During OWN0: req0 drops on the same cycle req1 rises → direct OWN1 on the next edge. Then assert `rst` mid-OWN1 → `gnt1`=0 and `sel`=0 immediately, without a clock edge.
